// File: rtl/mem_access_unit.sv
// Initiator-side controller for a single-port synchronous memory.
// Accepts CPU load/store requests over valid/ready, drives registered memory
// address/data/write-enable, and returns read bursts (1..16 beats), write
// acks and out-of-range errors as a single-cycle-per-beat response stream.
module mem_access_unit #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 16384,
  parameter int unsigned LEN_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_DEPTH - 1);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    issued;
  logic [LEN_W-1:0]  received;
  logic              primed;
  logic [ADDR_W:0]   end_addr;
  logic              req_bad;

  assign req_ready = (state == IDLE);

  // Range check on a one-bit-wider sum so a burst cannot wrap past the top.
  always_comb begin
    end_addr = {1'b0, req_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, req_len};
    req_bad  = ({1'b0, req_addr} >= DEPTH) || (end_addr > LAST_ADDR) ||
               (req_write && (req_len != '0));
  end

  // Request FSM with registered memory-side and response-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
      len_q      <= '0;
      issued     <= '0;
      received   <= '0;
      primed     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              state <= ERR;
            end else if (req_write) begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              mem_addr <= req_addr;
              len_q    <= req_len;
              issued   <= (LEN_W+1)'(1);
              received <= '0;
              primed   <= 1'b0;
              state    <= READ;
            end
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_last  <= 1'b1;
          resp_data  <= '0;
          state      <= IDLE;
        end
        READ: begin
          // Issue and receive run concurrently; receive trails issue by two
          // edges because memory data lands one cycle after its address edge.
          if (issued <= {1'b0, len_q}) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            issued   <= issued + (LEN_W+1)'(1);
          end
          if (!primed) begin
            primed <= 1'b1;
          end else begin
            resp_valid <= 1'b1;
            resp_data  <= mem_rdata;
            received   <= received + LEN_W'(1);
            if (received == len_q) begin
              resp_last <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_last  <= 1'b1;
          resp_data  <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: memory model, transaction-level expectation
// model checked every cycle, and directed scenarios with literal pins.
module tb_mem_access_unit;

  localparam int NC = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [3:0]  req_len;
  logic        resp_valid, resp_last, resp_err;
  logic [15:0] resp_data;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit in_rst;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(16384), .LEN_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory plus a preload port for the bench.
  logic [15:0] tb_mem [0:16383];
  logic        pre_en = 1'b0;
  logic [13:0] pre_addr;
  logic [15:0] pre_data;
  always @(posedge clk) begin
    if (pre_en) tb_mem[pre_addr] <= pre_data;
    else if (mem_we) tb_mem[mem_addr[13:0]] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr[13:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour per cycle, filled in at accept time.
  logic [15:0] ref_mem [0:16383];
  bit          busy [NC];
  bit          ev_v [NC];
  bit          ev_l [NC];
  bit          ev_e [NC];
  logic [15:0] ev_d [NC];
  bit          we_x [NC];
  logic [15:0] we_a [NC];
  logic [15:0] we_d [NC];

  int          obs_c [$];
  logic [15:0] obs_d [$];
  bit          obs_l [$];
  bit          obs_e [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the expectation model.
  always @(negedge clk) begin
    if (in_rst) begin
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'd0);
      chk("rst_resp_last", 32'(resp_last), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
    end else if (cyc < NC) begin
      chk("req_ready", 32'(req_ready), 32'(!busy[cyc]));
      chk("resp_valid", 32'(resp_valid), 32'(ev_v[cyc]));
      chk("resp_last", 32'(resp_last), 32'(ev_l[cyc]));
      chk("resp_err", 32'(resp_err), 32'(ev_e[cyc]));
      if (ev_v[cyc]) chk("resp_data", 32'(resp_data), 32'(ev_d[cyc]));
      chk("mem_we", 32'(mem_we), 32'(we_x[cyc]));
      if (we_x[cyc]) begin
        chk("mem_addr", 32'(mem_addr), 32'(we_a[cyc]));
        chk("mem_wdata", 32'(mem_wdata), 32'(we_d[cyc]));
      end
    end
    if (resp_valid === 1'b1) begin
      obs_c.push_back(cyc);
      obs_d.push_back(resp_data);
      obs_l.push_back(resp_last);
      obs_e.push_back(resp_err);
    end
  end

  // Transaction model: accept edge c opens interval c.
  task automatic model_accept(input int c, input bit w, input int a, input int d, input int l);
    bit err;
    err = (a >= 16384) || (a + l > 16383) || (w && l != 0);
    if (c + l + 3 >= NC) begin
      $display("FAIL cycle_budget cycle=%0d", c);
      $fatal(1);
    end
    if (err) begin
      busy[c] = 1'b1;
      ev_v[c+1] = 1'b1; ev_l[c+1] = 1'b1; ev_e[c+1] = 1'b1; ev_d[c+1] = 16'h0;
    end else if (w) begin
      busy[c] = 1'b1;
      we_x[c] = 1'b1; we_a[c] = 16'(a); we_d[c] = 16'(d);
      ref_mem[a] = 16'(d);
      ev_v[c+1] = 1'b1; ev_l[c+1] = 1'b1; ev_d[c+1] = 16'h0;
    end else begin
      for (int i = 0; i <= l + 1; i++) busy[c+i] = 1'b1;
      for (int k = 0; k <= l; k++) begin
        ev_v[c+2+k] = 1'b1;
        ev_d[c+2+k] = ref_mem[a+k];
        ev_l[c+2+k] = (k == l);
      end
    end
  endtask

  // Called at a negedge; returns the accept edge index.
  task automatic send(input bit w, input int a, input int d, input int l, output int acc);
    req_write = w; req_addr = 16'(a); req_wdata = 16'(d); req_len = 4'(l);
    req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 64; k++) begin
      if (!busy[cyc]) begin
        acc = cyc + 1;
        model_accept(acc, w, a, d, l);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input int a, input int d);
    ref_mem[a] = 16'(d);
    pre_addr = 14'(a); pre_data = 16'(d); pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Called at a negedge; asserts reset mid-cycle and cancels pending activity.
  task automatic reset_pulse();
    #1 reset = 1'b0;
    in_rst = 1'b1;
    for (int i = cyc + 1; i < NC; i++) begin
      busy[i] = 1'b0; ev_v[i] = 1'b0; ev_l[i] = 1'b0; ev_e[i] = 1'b0; we_x[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    in_rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc2, o;
    logic [15:0] burst [4];
    burst[0] = 16'h1111; burst[1] = 16'h2222; burst[2] = 16'h3333; burst[3] = 16'h4444;
    reset = 1'b1; in_rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    #1 reset = 1'b0; in_rst = 1'b1;
    for (int i = 0; i < 4; i++) preload(16'h0100 + i, 32'(burst[i]));
    for (int i = 0; i < 16; i++) preload(16'h0200 + i, 16'hA000 + i);
    for (int i = 0; i < 4; i++) preload(16'h3FFC + i, 16'hC0DE + (i << 8));
    preload(16'h0010, 16'h0000);
    #1 reset = 1'b1; in_rst = 1'b0;
    @(negedge clk);
    idle(3);

    // Single write
    o = obs_d.size();
    send(1'b1, 16'h0010, 16'hBEEF, 0, acc);
    idle(4);
    chk("wr_ack_count", 32'(obs_d.size() - o), 32'd1);
    if (obs_d.size() > o) begin
      chk("wr_ack_latency", 32'(obs_c[o] - acc), 32'd1);
      chk("wr_ack_data", 32'(obs_d[o]), 32'h0);
      chk("wr_ack_err", 32'(obs_e[o]), 32'd0);
    end
    chk("wr_mem_content", 32'(tb_mem[16'h0010]), 32'hBEEF);

    // Idle reset mid-sim
    reset_pulse();
    idle(2);

    // Burst read of 4
    o = obs_d.size();
    send(1'b0, 16'h0100, 0, 3, acc);
    idle(8);
    chk("rd4_count", 32'(obs_d.size() - o), 32'd4);
    if (obs_d.size() >= o + 4) begin
      chk("rd4_latency", 32'(obs_c[o] - acc), 32'd2);
      for (int k = 0; k < 4; k++) begin
        chk("rd4_data", 32'(obs_d[o+k]), 32'(burst[k]));
        chk("rd4_last", 32'(obs_l[o+k]), 32'(k == 3));
        chk("rd4_gap", 32'(obs_c[o+k] - obs_c[o]), 32'(k));
      end
    end

    // Out-of-range and malformed requests
    o = obs_d.size();
    send(1'b0, 16'h3FFC, 0, 4, acc);
    idle(3);
    send(1'b1, 16'h4000, 16'h5A5A, 0, acc);
    idle(3);
    send(1'b1, 16'h0030, 16'h5A5A, 2, acc);
    idle(3);
    chk("err_count", 32'(obs_d.size() - o), 32'd3);
    if (obs_d.size() >= o + 3) begin
      chk("err_latency", 32'(obs_c[o+2] - acc), 32'd1);
      for (int k = 0; k < 3; k++) begin
        chk("err_flag", 32'(obs_e[o+k]), 32'd1);
        chk("err_data", 32'(obs_d[o+k]), 32'h0);
      end
    end

    // Top-of-memory boundaries
    o = obs_d.size();
    send(1'b0, 16'h3FFF, 0, 0, acc);
    idle(4);
    send(1'b0, 16'h3FFC, 0, 3, acc);
    idle(7);
    chk("top_count", 32'(obs_d.size() - o), 32'd5);
    if (obs_d.size() >= o + 5) begin
      chk("top_single_data", 32'(obs_d[o]), 32'hC3DE);
      chk("top_single_err", 32'(obs_e[o]), 32'd0);
      chk("top_burst_first", 32'(obs_d[o+1]), 32'hC0DE);
      chk("top_burst_last", 32'(obs_d[o+4]), 32'hC3DE);
    end

    // Back-to-back read then write with valid held
    o = obs_d.size();
    send(1'b0, 16'h0100, 0, 1, acc);
    send(1'b1, 16'h0020, 16'h1234, 0, acc2);
    idle(4);
    chk("b2b_accept_gap", 32'(acc2 - acc), 32'd4);
    chk("b2b_count", 32'(obs_d.size() - o), 32'd3);
    if (obs_d.size() >= o + 3) begin
      chk("b2b_rd_last", 32'(obs_d[o+1]), 32'h2222);
      chk("b2b_ack_latency", 32'(obs_c[o+2] - acc2), 32'd1);
    end
    chk("b2b_mem_content", 32'(tb_mem[16'h0020]), 32'h1234);

    // Reset during a 16-beat burst after beat 5
    o = obs_d.size();
    send(1'b0, 16'h0200, 0, 15, acc);
    for (int k = 0; k < 40 && cyc < acc + 7; k++) @(negedge clk);
    reset_pulse();
    idle(20);
    chk("abort_count", 32'(obs_d.size() - o), 32'd6);
    if (obs_d.size() >= o + 6) chk("abort_beat5", 32'(obs_d[o+5]), 32'hA005);
    o = obs_d.size();
    send(1'b0, 16'h0200, 0, 0, acc);
    idle(4);
    chk("post_abort_count", 32'(obs_d.size() - o), 32'd1);
    if (obs_d.size() > o) chk("post_abort_data", 32'(obs_d[o]), 32'hA000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
